// File: rtl/riscv_pkg.sv
// Shared FPU front-end types: FCLASS bit positions, class flags, unpacker states.
package riscv_pkg;

  localparam int FCLASS_NEG_INF  = 0;
  localparam int FCLASS_NEG_NORM = 1;
  localparam int FCLASS_NEG_SUB  = 2;
  localparam int FCLASS_NEG_ZERO = 3;
  localparam int FCLASS_POS_ZERO = 4;
  localparam int FCLASS_POS_SUB  = 5;
  localparam int FCLASS_POS_NORM = 6;
  localparam int FCLASS_POS_INF  = 7;
  localparam int FCLASS_SNAN     = 8;
  localparam int FCLASS_QNAN     = 9;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
    logic is_subnormal;
  } fp_class_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_OUT  = 2'd2
  } unpack_state_t;

endpackage

// File: rtl/fp_operand_class.sv
// Combinational IEEE 754 classifier: class flags plus RISC-V FCLASS mask.
module fp_operand_class
  import riscv_pkg::*;
#(
  parameter int FP_WIDTH = 32,
  parameter int ExpBits  = 8,
  parameter int FracBits = 23
) (
  input  logic [FP_WIDTH-1:0] i_operand,
  output fp_class_t           o_class,
  output logic [9:0]          o_fclass
);

  logic                sign;
  logic [ExpBits-1:0]  e;
  logic [FracBits-1:0] f;
  logic                e_max;
  logic                e_zero;
  logic                f_zero;

  assign sign   = i_operand[FP_WIDTH-1];
  assign e      = i_operand[FP_WIDTH-2 -: ExpBits];
  assign f      = i_operand[FracBits-1:0];
  assign e_max  = &e;
  assign e_zero = ~|e;
  assign f_zero = ~|f;

  always_comb begin
    o_class              = '0;
    o_class.is_zero      = e_zero & f_zero;
    o_class.is_subnormal = e_zero & ~f_zero;
    o_class.is_inf       = e_max & f_zero;
    o_class.is_nan       = e_max & ~f_zero;
    o_class.is_snan      = e_max & ~f_zero & ~f[FracBits-1];
  end

  always_comb begin
    o_fclass = '0;
    unique case (1'b1)
      o_class.is_nan: begin
        if (o_class.is_snan) o_fclass[FCLASS_SNAN] = 1'b1;
        else                 o_fclass[FCLASS_QNAN] = 1'b1;
      end
      o_class.is_inf:
        o_fclass[sign ? FCLASS_NEG_INF : FCLASS_POS_INF] = 1'b1;
      o_class.is_zero:
        o_fclass[sign ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO] = 1'b1;
      o_class.is_subnormal:
        o_fclass[sign ? FCLASS_NEG_SUB : FCLASS_POS_SUB] = 1'b1;
      default:
        o_fclass[sign ? FCLASS_NEG_NORM : FCLASS_POS_NORM] = 1'b1;
    endcase
  end

endmodule

// File: rtl/fp_operand_unpacker.sv
// FPU operand front end: classify, unpack and iteratively normalize subnormals.
module fp_operand_unpacker
  import riscv_pkg::*;
#(
  parameter int FP_WIDTH   = 32,
  parameter int ExpBits    = 8,
  parameter int FracBits   = 23,
  parameter int MantBits   = 24,
  parameter int ExpExtBits = 10,
  parameter int ShiftStep  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [FP_WIDTH-1:0]          i_operand,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_sign,
  output logic signed [ExpExtBits-1:0] o_exp,
  output logic [MantBits-1:0]          o_mantissa,
  output logic                         o_is_zero,
  output logic                         o_is_inf,
  output logic                         o_is_nan,
  output logic                         o_is_snan,
  output logic                         o_is_subnormal,
  output logic [9:0]                   o_fclass
);

  localparam int LzW = $clog2(MantBits + 1);
  localparam logic [LzW-1:0] Step = LzW'(ShiftStep);

  if (1 - (MantBits - 1) < -(2 ** (ExpExtBits - 1))) begin : g_exp_chk
    $error("ExpExtBits too narrow for normalized subnormal exponent");
  end
  if (ShiftStep < 1 || ShiftStep > MantBits - 1) begin : g_step_chk
    $error("ShiftStep out of range");
  end
  if (MantBits != FracBits + 1 || FP_WIDTH != 1 + ExpBits + FracBits) begin : g_fmt_chk
    $error("inconsistent format parameters");
  end

  unpack_state_t               state_q, state_d;
  logic                        en_q, en_d;
  logic                        valid_q, valid_d;
  logic                        sign_q, sign_d;
  logic signed [ExpExtBits-1:0] exp_q, exp_d;
  logic [MantBits-1:0]         mant_q, mant_d;
  fp_class_t                   cls_q, cls_d;
  logic [9:0]                  fclass_q, fclass_d;

  fp_class_t           cls_w;
  logic [9:0]          fclass_w;
  logic [ExpBits-1:0]  e_in;
  logic [FracBits-1:0] f_in;
  logic                accept;

  fp_operand_class #(
    .FP_WIDTH (FP_WIDTH),
    .ExpBits  (ExpBits),
    .FracBits (FracBits)
  ) u_class (
    .i_operand (i_operand),
    .o_class   (cls_w),
    .o_fclass  (fclass_w)
  );

  assign e_in = i_operand[FP_WIDTH-2 -: ExpBits];
  assign f_in = i_operand[FracBits-1:0];

  assign o_ready = en_q & ~i_flush &
                   ((state_q == S_IDLE) | ((state_q == S_OUT) & i_ready));
  assign accept  = i_valid & o_ready;

  logic [LzW-1:0]               lz;
  logic                         hit;
  logic [LzW-1:0]               step;
  logic [MantBits-1:0]          mant_sh;
  logic signed [ExpExtBits-1:0] exp_sh;

  always_comb begin
    lz  = '0;
    hit = 1'b0;
    for (int i = MantBits - 1; i >= 0; i--) begin
      if (mant_q[i])  hit = 1'b1;
      else if (!hit)  lz  = lz + LzW'(1);
    end
  end

  assign step    = (lz < Step) ? lz : Step;
  assign mant_sh = mant_q << step;
  assign exp_sh  = exp_q - $signed({{(ExpExtBits-LzW){1'b0}}, step});

  always_comb begin
    state_d  = state_q;
    en_d     = 1'b1;
    valid_d  = valid_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    cls_d    = cls_q;
    fclass_d = fclass_q;
    if (i_flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_NORM: begin
          mant_d = mant_sh;
          exp_d  = exp_sh;
          if (mant_sh[MantBits-1]) begin
            state_d = S_OUT;
            valid_d = 1'b1;
          end
        end
        S_OUT: begin
          if (i_ready) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end
        end
        default: ;
      endcase
      // A capture overrides the consume path so OUT can refill every cycle
      if (accept) begin
        sign_d   = i_operand[FP_WIDTH-1];
        cls_d    = cls_w;
        fclass_d = fclass_w;
        mant_d   = {|e_in, f_in};
        exp_d    = cls_w.is_subnormal ? ExpExtBits'(1)
                 : $signed({{(ExpExtBits-ExpBits){1'b0}}, e_in});
        state_d  = cls_w.is_subnormal ? S_NORM : S_OUT;
        valid_d  = ~cls_w.is_subnormal;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      valid_q  <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      cls_q    <= '0;
      fclass_q <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      valid_q  <= valid_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      cls_q    <= cls_d;
      fclass_q <= fclass_d;
    end
  end

  assign o_valid        = valid_q;
  assign o_sign         = sign_q;
  assign o_exp          = exp_q;
  assign o_mantissa     = mant_q;
  assign o_is_zero      = cls_q.is_zero;
  assign o_is_inf       = cls_q.is_inf;
  assign o_is_nan       = cls_q.is_nan;
  assign o_is_snan      = cls_q.is_snan;
  assign o_is_subnormal = cls_q.is_subnormal;
  assign o_fclass       = fclass_q;

endmodule

// File: tb/tb_fp_operand_unpacker.sv
// Directed bench for fp_operand_unpacker with hand-computed expectations.
module tb_fp_operand_unpacker;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              vld = 1'b0;
  logic              ordy;
  logic [31:0]       op = '0;
  logic              o_valid;
  logic              rdy = 1'b0;
  logic              o_sign;
  logic signed [9:0] o_exp;
  logic [23:0]       o_mant;
  logic              z, inf, nan, snan, sub;
  logic [9:0]        fcls;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_operand_unpacker dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_valid        (vld),
    .o_ready        (ordy),
    .i_operand      (op),
    .o_valid        (o_valid),
    .i_ready        (rdy),
    .o_sign         (o_sign),
    .o_exp          (o_exp),
    .o_mantissa     (o_mant),
    .o_is_zero      (z),
    .o_is_inf       (inf),
    .o_is_nan       (nan),
    .o_is_snan      (snan),
    .o_is_subnormal (sub),
    .o_fclass       (fcls)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if ({o_valid, ordy, o_sign, o_exp, o_mant} !== 37'h0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0", {o_valid, ordy, o_sign, o_exp, o_mant});
    end
    n_cmp++;
    if ({z, inf, nan, snan, sub, fcls} !== 15'h0) begin
      n_bad++;
      $display("FAIL reset_flags got %h want 0", {z, inf, nan, snan, sub, fcls});
    end
    #1 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ordy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready_pre got %b want 0", ordy);
    end
    tick();
    n_cmp++;
    if (ordy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_post got %b want 1", ordy);
    end
  endtask

  task automatic test_normal;
    rdy = 1'b1;
    op  = 32'h3F800000;
    vld = 1'b1;
    #1;
    n_cmp++;
    if (ordy !== 1'b1) begin
      n_bad++;
      $display("FAIL norm_ready got %b want 1", ordy);
    end
    tick();
    n_cmp++;
    if ({o_valid, o_sign, o_exp, o_mant} !== {1'b1, 1'b0, 10'd127, 24'h800000}) begin
      n_bad++;
      $display("FAIL norm_one got %h want %h", {o_valid, o_sign, o_exp, o_mant},
               {1'b1, 1'b0, 10'd127, 24'h800000});
    end
    n_cmp++;
    if ({z, inf, nan, snan, sub, fcls} !== {5'b0, 10'h040}) begin
      n_bad++;
      $display("FAIL norm_one_class got %h want %h", {z, inf, nan, snan, sub, fcls},
               {5'b0, 10'h040});
    end
    op = 32'h40000000;
    tick();
    n_cmp++;
    if ({o_valid, o_sign, o_exp, o_mant} !== {1'b1, 1'b0, 10'd128, 24'h800000}) begin
      n_bad++;
      $display("FAIL norm_b2b got %h want %h", {o_valid, o_sign, o_exp, o_mant},
               {1'b1, 1'b0, 10'd128, 24'h800000});
    end
    vld = 1'b0;
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL norm_drain got %b want 0", o_valid);
    end
  endtask

  task automatic test_subnormal;
    rdy = 1'b1;
    op  = 32'h00000001;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({o_valid, ordy} !== 2'b00) begin
        n_bad++;
        $display("FAIL sub_norm_cyc%0d got %b want 00", i, {o_valid, ordy});
      end
      if (i < 2) tick();
    end
    tick();
    n_cmp++;
    if ({o_valid, o_sign, o_exp, o_mant} !== {1'b1, 1'b0, 10'h3EA, 24'h800000}) begin
      n_bad++;
      $display("FAIL sub_result got %h want %h", {o_valid, o_sign, o_exp, o_mant},
               {1'b1, 1'b0, 10'h3EA, 24'h800000});
    end
    n_cmp++;
    if ({z, inf, nan, snan, sub, fcls} !== {5'b00001, 10'h020}) begin
      n_bad++;
      $display("FAIL sub_class got %h want %h", {z, inf, nan, snan, sub, fcls},
               {5'b00001, 10'h020});
    end
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_drain got %b want 0", o_valid);
    end
  endtask

  logic [31:0] sp_op   [4] = '{32'hFF800000, 32'h7F800001, 32'h7FC00000, 32'h80000000};
  logic [34:0] sp_data [4] = '{{1'b1, 10'd255, 24'h800000}, {1'b0, 10'd255, 24'h800001},
                               {1'b0, 10'd255, 24'hC00000}, {1'b1, 10'd0, 24'h000000}};
  logic [14:0] sp_cls  [4] = '{{5'b01000, 10'h001}, {5'b00110, 10'h100},
                               {5'b00100, 10'h200}, {5'b10000, 10'h008}};

  task automatic test_specials;
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op  = sp_op[i];
      vld = 1'b1;
      tick();
      vld = 1'b0;
      n_cmp++;
      if ({o_valid, o_sign, o_exp, o_mant} !== {1'b1, sp_data[i]}) begin
        n_bad++;
        $display("FAIL special_%h_data got %h want %h", sp_op[i],
                 {o_valid, o_sign, o_exp, o_mant}, {1'b1, sp_data[i]});
      end
      n_cmp++;
      if ({z, inf, nan, snan, sub, fcls} !== sp_cls[i]) begin
        n_bad++;
        $display("FAIL special_%h_class got %h want %h", sp_op[i],
                 {z, inf, nan, snan, sub, fcls}, sp_cls[i]);
      end
      tick();
    end
  endtask

  task automatic test_hold;
    rdy = 1'b0;
    op  = 32'h40490FDB;
    vld = 1'b1;
    tick();
    op = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({o_valid, ordy, o_sign, o_exp, o_mant, fcls} !==
          {1'b1, 1'b0, 1'b0, 10'd128, 24'hC90FDB, 10'h040}) begin
        n_bad++;
        $display("FAIL hold_cyc%0d got %h want %h", i,
                 {o_valid, ordy, o_sign, o_exp, o_mant, fcls},
                 {1'b1, 1'b0, 1'b0, 10'd128, 24'hC90FDB, 10'h040});
      end
      tick();
    end
    vld = 1'b0;
    rdy = 1'b1;
    #1;
    n_cmp++;
    if ({o_valid, ordy} !== 2'b11) begin
      n_bad++;
      $display("FAIL hold_release got %b want 11", {o_valid, ordy});
    end
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_consumed got %b want 0", o_valid);
    end
  endtask

  task automatic test_flush;
    rdy = 1'b1;
    op  = 32'h00000001;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, ordy} !== 2'b01) begin
      n_bad++;
      $display("FAIL flush_idle got %b want 01", {o_valid, ordy});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (o_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL flush_quiet%0d got %b want 0", i, o_valid);
      end
    end
    op    = 32'h3F800000;
    vld   = 1'b1;
    flush = 1'b1;
    #1;
    n_cmp++;
    if (ordy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_gate got %b want 0", ordy);
    end
    tick();
    flush = 1'b0;
    vld   = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, ordy} !== 2'b01) begin
      n_bad++;
      $display("FAIL flush_drop got %b want 01", {o_valid, ordy});
    end
  endtask

  task automatic test_reset_mid;
    rdy = 1'b1;
    op  = 32'h00000001;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, ordy, o_sign, o_exp, o_mant, z, inf, nan, snan, sub, fcls} !== 52'h0) begin
      n_bad++;
      $display("FAIL rstmid_zero got %h want 0",
               {o_valid, ordy, o_sign, o_exp, o_mant, z, inf, nan, snan, sub, fcls});
    end
    #1 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ordy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_ready_pre got %b want 0", ordy);
    end
    tick();
    n_cmp++;
    if ({o_valid, ordy, o_exp} !== {1'b0, 1'b1, 10'd0}) begin
      n_bad++;
      $display("FAIL rstmid_ready_post got %h want %h", {o_valid, ordy, o_exp},
               {1'b0, 1'b1, 10'd0});
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_no_result got %b want 0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_subnormal();
    test_specials();
    test_hold();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_operand_unpacker.md
Name: fp_operand_unpacker

Overview:
Front-end operand decoder for the FPU arithmetic units (adder, multiplier, divider, sqrt, fma). It produces the working format that fp_result_assembler consumes on the back end.
- Accepts one packed IEEE 754 operand per handshake.
- Classifies it and extracts sign, extended biased exponent and mantissa with explicit leading bit.
- Normalizes subnormals iteratively, up to ShiftStep bits per cycle.
- Presents the result on a valid/ready output.

Parameters:
FP_WIDTH, 32, packed operand width
ExpBits, 8, exponent field width
FracBits, 23, fraction field width
MantBits, 24, FracBits+1
ExpExtBits, 10, signed working exponent width
ShiftStep, 8, maximum left-shift per normalization cycle (1..MantBits-1)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  synchronous discard of in-flight operand
i_valid  in  1  input operand valid
o_ready  out  1  unpacker can accept
i_operand  in  FP_WIDTH  packed operand
o_valid  out  1  unpacked result valid
i_ready  in  1  consumer accepts result
o_sign  out  1  operand sign
o_exp  out  ExpExtBits (signed)  biased exponent; subnormals normalized, so it may be <=0
o_mantissa  out  MantBits  mantissa, MSB is explicit leading bit
o_is_zero, o_is_inf, o_is_nan, o_is_snan, o_is_subnormal  out  1 each  class flags
o_fclass  out  10  RISC-V FCLASS one-hot mask

Behaviour:
- Clock and reset are fixed: one clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset state:
  - state=IDLE.
  - All output registers are 0: o_valid=0, o_sign=0, o_exp=0, o_mantissa=0, all flags=0, o_fclass=0.
  - o_ready is a registered enable, reset to 0, and rises on the first clock after reset release.
- States:
  - IDLE: o_ready=1.
  - NORM: o_ready=0.
  - OUT: o_valid=1; o_ready=i_ready.
- Accept: a transfer happens when i_valid && o_ready && !i_flush. At the accepting edge the block captures sign, exponent field e, fraction f and class.
- Normal operand (0<e<ExpMax):
  - o_exp=e; o_mantissa={1,f}.
  - Next state OUT, so latency is 1.
- Zero, Inf, NaN: no normalization, next state OUT.
  - Zero: o_exp=0, o_mantissa=0.
  - Inf/NaN: o_exp=ExpMax (zero-extended), o_mantissa={1,f}.
- Subnormal (e==0, f!=0):
  - Load o_exp=1 and o_mantissa={0,f}, then go to NORM.
  - In each NORM cycle, compute lz = leading-zero count of the mantissa and s=min(lz,ShiftStep). Shift the mantissa left by s and subtract s from the exponent.
  - When the shifted MSB is 1, go to OUT.
  - Latency = 1 + ceil(lz0/ShiftStep), where lz0 is the initial leading-zero count.
  - Final o_exp = 1 - lz0.
- OUT:
  - Outputs are held stable while !i_ready.
  - On i_ready the result is consumed. If a new input transfers in the same cycle, it is captured as above (throughput 1/cycle for normals). Otherwise go to IDLE and clear o_valid.
- Flush:
  - i_flush in any state returns the block to IDLE and clears o_valid.
  - When i_flush and i_valid coincide, flush wins: o_ready is gated low and the input is dropped.
- Mid-operation reset: asynchronous return to reset values, including from NORM.
- Classification:
  - NaN: e==ExpMax && f!=0.
  - sNaN: NaN with f[FracBits-1]==0.
  - o_fclass bits follow RISC-V: 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
  - Exactly one fclass bit is set whenever o_valid=1.
- Flags and o_fclass are registered at accept and unchanged by normalization.
- Widths: exponent arithmetic is signed ExpExtBits. The minimum value 1-(MantBits-1) must fit, and an elaboration assertion checks it.

Decomposition:
- riscv_pkg: FCLASS bit-index constants (FCLASS_NEG_INF .. FCLASS_QNAN), and an fp_class_t packed struct holding the five class flags.
- Sub-module fp_operand_class (combinational): packed operand -> fp_class_t and 10-bit fclass.
- Leading-zero count and FSM stay in fp_operand_unpacker.

Test Plan:
- 0x3F800000 accepted with i_ready=1 -> next cycle o_valid=1, sign 0, o_exp=127, o_mantissa=0x800000, fclass bit 6; back-to-back 0x40000000 gives o_exp=128 on the following cycle.
- 0x00000001, ShiftStep=8 -> o_valid 4 cycles after accept, o_exp=-22, o_mantissa=0x800000, o_is_subnormal=1, fclass bit 5; o_ready=0 during NORM.
- 0xFF800000 -> o_is_inf=1, fclass bit 0, o_exp=255; 0x7F800001 -> o_is_snan=1, fclass bit 8; 0x7FC00000 -> qNaN, fclass bit 9; 0x80000000 -> o_is_zero=1, fclass bit 3.
- Result held with i_ready=0 for 5 cycles -> all outputs stable and o_ready=0; i_ready=1 -> consumed, o_valid falls next cycle.
- i_flush asserted in the second NORM cycle of 0x00000001 -> IDLE next cycle, o_valid never asserted; i_flush together with i_valid -> input dropped.
- i_rst_n pulsed low mid-NORM -> outputs 0 immediately; o_ready=0 until the first clock after release, then 1.
